// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Iterative 32x32 multiply / divide unit for a MIPS-style HI/LO pipeline.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring shift-subtract.
//   Each operation takes one 32-iteration RUN phase. A one-cycle DONE phase
//   follows RUN and pulses hilo_we with the HI/LO results.
//
//   Ports
//     clk      in   clock, all state on rising edge
//     rst      in   synchronous active-high reset (wins over everything)
//     start    in   operation request, only looked at in IDLE
//     op[1:0]  in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a[31:0]  in   rs operand (multiplicand / dividend)
//     b[31:0]  in   rt operand (multiplier / divisor)
//     cancel   in   pipeline flush, aborts a pending operation
//     stall    out  combinational pipeline freeze
//     busy     out  registered, high in RUN and DONE
//     hilo_we  out  one-cycle HI/LO write strobe
//     hi_out   out  HI result, held between operations
//     lo_out   out  LO result, held between operations
//
//   Optional feature (compile-time macro MULDIV_DIVZERO_EARLY_EN):
//     When the macro is defined, DIV/DIVU by zero skips RUN and goes from
//     IDLE to DONE. The results are the same as those of the full
//     32-iteration run.
// -----------------------------------------------------------------------------
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        stall,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q;
    logic [1:0]  op_q, op_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [31:0] opnd_q, opnd_d;   // |multiplicand| or |divisor|
    logic [32:0] rem_q, rem_d;     // product high half / partial remainder
    logic [31:0] quo_q, quo_d;     // multiplier bits / dividend -> quotient
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? -x : x;
    endfunction

    // Apply the sign rules to the magnitude results. The result is {HI, LO}.
    function automatic logic [63:0] finalize(input logic [1:0]  f_op,
                                             input logic        f_sa,
                                             input logic        f_sb,
                                             input logic [31:0] hi_mag,
                                             input logic [31:0] lo_mag);
        logic [63:0] prod;
        logic [31:0] q;
        logic [31:0] r;
        prod = {hi_mag, lo_mag};
        q    = lo_mag;
        r    = hi_mag;
        if (!f_op[1]) begin
            if (f_sa ^ f_sb) prod = -prod;
            return prod;
        end
        if (f_sa ^ f_sb) q = -q;
        if (f_sa)        r = -r;
        return {r, q};
    endfunction

    // The multiply step adds the multiplicand when the current multiplier
    // LSB is set. The sum is then shifted right together with the multiplier.
    assign mul_sum   = rem_q + {1'b0, (quo_q[0] ? opnd_q : 32'd0)};
    // The divide step shifts in the next dividend bit and trial-subtracts.
    // Bit 33 of the difference is the borrow.
    assign div_shift = {rem_q[31:0], quo_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;
        hilo_we = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    stall   = 1'b1;
                    op_d    = op;
                    sa_d    = ~op[0] & a[31];
                    sb_d    = ~op[0] & b[31];
                    opnd_d  = op[0] ? b : abs32(b);
                    quo_d   = op[0] ? a : abs32(a);
                    rem_d   = 33'd0;
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
`ifdef MULDIV_DIVZERO_EARLY_EN
                    if (op[1] && (b == 32'd0)) begin
                        state_d      = S_DONE;
                        {hi_d, lo_d} = finalize(op, ~op[0] & a[31], 1'b0,
                                                (op[0] ? a : abs32(a)),
                                                32'hFFFF_FFFF);
                    end
`endif
                end
            end

            S_RUN: begin
                stall = 1'b1;
                if (op_q[1]) begin
                    if (!div_diff[33]) begin
                        rem_d = div_diff[32:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = div_shift;
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                end else begin
                    rem_d = {1'b0, mul_sum[32:1]};
                    quo_d = {mul_sum[0], quo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 5'd31) begin
                    state_d      = S_DONE;
                    // After 32 steps, {rem, quo} holds either {product hi, lo}
                    // or {remainder, quotient}. Both cases map to {HI, LO}.
                    {hi_d, lo_d} = finalize(op_q, sa_q, sb_q, rem_d[31:0], quo_d);
                end
            end

            S_DONE: begin
                stall   = 1'b1;
                hilo_we = ~cancel & ~rst;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
        op_q   <= op_d;
        sa_q   <= sa_d;
        sb_q   <= sb_d;
        opnd_q <= opnd_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
    end

    assign busy   = busy_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        stall, busy, hilo_we;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MULDIV_DIVZERO_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .stall(stall), .busy(busy), .hilo_we(hilo_we),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // Reference model computed with plain 64-bit arithmetic. Returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] mop,
                                          input logic [31:0] ma, input logic [31:0] mb);
        longint x, y, q, r;
        logic [63:0] p;
        case (mop)
            2'd0: begin x = $signed(ma); y = $signed(mb); p = x * y; return p; end
            2'd1: begin p = {32'd0, ma} * {32'd0, mb}; return p; end
            2'd2: begin
                x = $signed(ma);
                if (mb == 32'd0) begin
                    q = (x < 0) ? -64'sd4294967295 : 64'sd4294967295;
                    return {ma, q[31:0]};
                end
                y = $signed(mb);
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
                return {ma % mb, ma / mb};
            end
        endcase
    endfunction

    // Drives one start (the caller must be at a negedge) and observes 36
    // cycles. If poke > 0, a stray start is driven in cycle poke.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke, output int lat, output int we_n,
                          output int st_n, output int bz_n,
                          output logic [31:0] rh, output logic [31:0] rl);
        op = o; a = x; b = y; start = 1'b1;
        lat = -1; we_n = 0; st_n = 0; bz_n = 0; rh = 32'd0; rl = 32'd0;
        #1;
        if (stall) st_n++;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            start = (k == poke);
            if (k == poke) begin op = ~o; a = $urandom; b = $urandom; end
            #1;
            if (stall) st_n++;
            if (busy) bz_n++;
            if (hilo_we) begin
                we_n++;
                if (lat < 0) begin lat = k; rh = hi_out; rl = lo_out; end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if ({busy, hilo_we, stall} !== 3'b000 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            n_errors++;
            $display("FAIL reset: busy=%b we=%b stall=%b hi=%h lo=%h, required all 0",
                     busy, hilo_we, stall, hi_out, lo_out);
        end
    endtask

    task automatic test_directed;
        logic [1:0]  vop[8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] va[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100,
                                32'h80000000, 32'd5, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] vb[8]  = '{32'd2, 32'd5, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd0,
                                32'h80000000};
        logic [31:0] vhi[8] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5,
                                32'hFFFFFFF9, 32'h40000000};
        logic [31:0] vlo[8] = '{32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'd14,
                                32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h0};
        int lat, we_n, st_n, bz_n, exp_lat;
        logic [31:0] rh, rl;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_lat = (EARLY && vop[i][1] && vb[i] == 32'd0) ? 1 : 33;
            run_op(vop[i], va[i], vb[i], 0, lat, we_n, st_n, bz_n, rh, rl);
            n_checks++;
            if (rh !== vhi[i] || rl !== vlo[i]) begin
                n_errors++;
                $display("FAIL directed[%0d] result: hi=%h lo=%h, required hi=%h lo=%h",
                         i, rh, rl, vhi[i], vlo[i]);
            end
            n_checks++;
            if (lat != exp_lat || we_n != 1) begin
                n_errors++;
                $display("FAIL directed[%0d] latency: lat=%0d pulses=%0d, required lat=%0d pulses=1",
                         i, lat, we_n, exp_lat);
            end
            n_checks++;
            if (st_n != exp_lat + 1 || bz_n != exp_lat) begin
                n_errors++;
                $display("FAIL directed[%0d] stall/busy: stall=%0d busy=%0d cycles, required %0d/%0d",
                         i, st_n, bz_n, exp_lat + 1, exp_lat);
            end
        end
    endtask

    task automatic test_random;
        int lat, we_n, st_n, bz_n, exp_lat;
        logic [31:0] rh, rl, x, y;
        logic [1:0]  o;
        logic [63:0] e;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 16);
                2:       y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            e = model(o, x, y);
            exp_lat = (EARLY && o[1] && y == 32'd0) ? 1 : 33;
            @(negedge clk);
            run_op(o, x, y, 0, lat, we_n, st_n, bz_n, rh, rl);
            n_checks++;
            if ({rh, rl} !== e || lat != exp_lat || we_n != 1) begin
                n_errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d pulses=%0d, required hi=%h lo=%h lat=%0d pulses=1",
                         i, o, x, y, rh, rl, lat, we_n, e[63:32], e[31:0], exp_lat);
            end
            n_checks++;
            if (hi_out !== e[63:32] || lo_out !== e[31:0]) begin
                n_errors++;
                $display("FAIL random[%0d] hold: hi=%h lo=%h, required hi=%h lo=%h",
                         i, hi_out, lo_out, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, we_n, st_n, bz_n;
        logic [31:0] rh, rl, x, y;
        logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom_range(1, 1000);
            e = model(2'd3, x, y);
            @(negedge clk);
            run_op(2'd3, x, y, 5 + 9 * i, lat, we_n, st_n, bz_n, rh, rl);
            n_checks++;
            if ({rh, rl} !== e || lat != 33 || we_n != 1 || bz_n != 33) begin
                n_errors++;
                $display("FAIL busy_ignore[%0d]: hi=%h lo=%h lat=%0d pulses=%0d busy=%0d, required hi=%h lo=%h lat=33 pulses=1 busy=33",
                         i, rh, rl, lat, we_n, bz_n, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_cancel;
        logic [31:0] h0, l0, rh, rl, x, y;
        logic [63:0] e;
        int we, lat, we_n, st_n, bz_n;
        @(negedge clk);
        h0 = hi_out; l0 = lo_out; we = 0;
        op = 2'd1; a = $urandom; b = $urandom; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
            cancel = (k == 11);
            #1;
            if (hilo_we) we++;
            if (k == 5) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL cancel busy_in_run: busy=%b, required 1", busy);
                end
            end
        end
        @(negedge clk); cancel = 1'b0; #1;
        if (hilo_we) we++;
        n_checks++;
        if (busy !== 1'b0 || we != 0 || hi_out !== h0 || lo_out !== l0) begin
            n_errors++;
            $display("FAIL cancel abort: busy=%b pulses=%0d hi=%h lo=%h, required busy=0 pulses=0 hi=%h lo=%h",
                     busy, we, hi_out, lo_out, h0, l0);
        end
        x = $urandom; y = $urandom; e = model(2'd0, x, y);
        run_op(2'd0, x, y, 0, lat, we_n, st_n, bz_n, rh, rl);
        n_checks++;
        if ({rh, rl} !== e || lat != 33 || we_n != 1) begin
            n_errors++;
            $display("FAIL cancel restart: hi=%h lo=%h lat=%0d pulses=%0d, required hi=%h lo=%h lat=33 pulses=1",
                     rh, rl, lat, we_n, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_rst_mid;
        int we;
        @(negedge clk);
        we = 0;
        op = 2'd0; a = $urandom | 32'h1; b = $urandom | 32'h1; start = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (k == 21);
            #1;
            if (hilo_we) we++;
        end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if ({busy, hilo_we, stall} !== 3'b000 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_mid outputs: busy=%b we=%b stall=%b hi=%h lo=%h, required all 0",
                     busy, hilo_we, stall, hi_out, lo_out);
        end
        for (int k = 0; k < 36; k++) begin
            @(negedge clk); #1;
            if (hilo_we) we++;
        end
        n_checks++;
        if (we != 0) begin
            n_errors++;
            $display("FAIL rst_mid pulses: pulses=%0d, required 0", we);
        end
    endtask

    task automatic test_start_cancel_idle;
        logic [31:0] h0, l0;
        int we;
        @(negedge clk);
        h0 = hi_out; l0 = lo_out; we = 0;
        op = 2'd1; a = $urandom; b = $urandom; start = 1'b1; cancel = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL start_cancel stall: stall=%b, required 0", stall);
        end
        @(negedge clk); start = 1'b0; cancel = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_cancel busy: busy=%b, required 0", busy);
        end
        for (int k = 0; k < 36; k++) begin
            @(negedge clk); #1;
            if (hilo_we) we++;
        end
        n_checks++;
        if (we != 0 || hi_out !== h0 || lo_out !== l0) begin
            n_errors++;
            $display("FAIL start_cancel no_op: pulses=%0d hi=%h lo=%h, required 0 %h %h",
                     we, hi_out, lo_out, h0, l0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_cancel();
        test_rst_mid();
        test_start_cancel_idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
